midi_uart_rx_p: RTL and testbench

- Parametrised MIDI receiver: oversampled UART front end with majority-vote sampling and framing-error detection, followed by a running-status parser.
- Realtime bytes (F8–FF) go to a dedicated one-cycle pulse path.
- All other bytes are tagged with current status and data-byte index, then queued in a small FIFO with a valid/ready handshake.
- Sits between the MIDI input pin and the synth voice/controller logic.

---
 rtl/midi_uart_rx_p.sv | 234 +++++++++++++++++++++++
 tb/tb_midi_uart_rx_p.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx_p.sv
// MIDI receiver: oversampled UART with majority vote, running-status tagger and a show-ahead FIFO.
// Byte strobes and FIFO write land 1 clock after the stop-bit decision; a push into a full FIFO with no pop is dropped (overrun_err).
`timescale 1ns/1ps
module midi_uart_rx_p #(
  parameter int CLK_HZ      = 25000000,
  parameter int BAUD        = 31250,
  parameter int OVS         = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          midi_rxd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_byte,
  output logic [7:0]                    out_status,
  output logic [7:0]                    out_nr,
  output logic                          out_is_status,
  output logic                          rt_valid,
  output logic [7:0]                    rt_byte,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_M1  = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST = OW'(OVS - 1);
  localparam logic [OW-1:0] OS_S0   = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] OS_S1   = OW'(OVS / 2);
  localparam logic [OW-1:0] OS_S2   = OW'(OVS / 2 + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] st;
    logic [7:0] nr;
    logic       is_st;
  } ent_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;
  logic [DW-1:0]          r_div;
  logic [OW-1:0]          r_os;
  logic [2:0]             r_bitn;
  logic [7:0]             r_shift;
  logic                   r_s0, r_s1;
  state_t                 r_state;
  logic                   r_frame_err;

  logic w_rx, w_fall, w_tick, w_maj, w_decide, w_restart, w_accept;

  assign w_rx      = r_sync[SYNC_STAGES-1];
  assign w_fall    = r_rx_d & ~w_rx;
  assign w_tick    = (r_div == DIV_M1);
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_decide  = w_tick && (r_os == OS_S2);
  assign w_restart = (r_state == S_IDLE) && w_fall;
  assign w_accept  = (r_state == S_STOP) && w_decide && w_maj;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], midi_rxd};
      r_rx_d <= w_rx;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)                    r_div <= '0;
    else if (w_restart || w_tick) r_div <= '0;
    else                          r_div <= r_div + 1'b1;
  end

  // The third vote is taken live from w_rx at the decision tick.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_os        <= '0;
      r_bitn      <= '0;
      r_shift     <= '0;
      r_s0        <= 1'b1;
      r_s1        <= 1'b1;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_tick && r_os == OS_S0) r_s0 <= w_rx;
      if (w_tick && r_os == OS_S1) r_s1 <= w_rx;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_os    <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_os <= (r_os == OS_LAST) ? '0 : r_os + 1'b1;
            if (w_decide && w_maj) r_state <= S_IDLE;
            else if (r_os == OS_LAST) begin
              r_state <= S_DATA;
              r_bitn  <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_os <= (r_os == OS_LAST) ? '0 : r_os + 1'b1;
            if (w_decide) r_shift <= {w_maj, r_shift[7:1]};
            if (r_os == OS_LAST) begin
              if (r_bitn == 3'd7) r_state <= S_STOP;
              r_bitn <= r_bitn + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_os <= r_os + 1'b1;
            if (w_decide) begin
              if (w_maj) r_state <= S_IDLE;
              else begin
                r_state     <= S_BREAK;
                r_frame_err <= 1'b1;
                r_os        <= '0;
              end
            end
          end
        end
        S_BREAK: begin
          if (!w_rx) r_os <= '0;
          else if (w_tick) begin
            if (r_os == OS_LAST) r_state <= S_IDLE;
            else                 r_os <= r_os + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [7:0] r_cur_status, r_nr, r_rt_byte;
  logic       r_rt_valid, r_push;
  ent_t       r_push_dat;
  logic [7:0] w_nr_new;

  assign w_nr_new = (r_nr == 8'hFF) ? 8'hFF : r_nr + 8'd1;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cur_status <= '0;
      r_nr         <= '0;
      r_rt_byte    <= '0;
      r_rt_valid   <= 1'b0;
      r_push       <= 1'b0;
      r_push_dat   <= '0;
    end else begin
      r_rt_valid <= 1'b0;
      r_push     <= 1'b0;
      if (w_accept) begin
        if (r_shift >= 8'hF8) begin
          r_rt_byte  <= r_shift;
          r_rt_valid <= 1'b1;
        end else if (r_shift == 8'hF7) begin
          r_push       <= 1'b1;
          r_push_dat   <= '{b: 8'hF7, st: r_cur_status, nr: 8'd0, is_st: 1'b1};
          r_cur_status <= '0;
          r_nr         <= '0;
        end else if (r_shift[7]) begin
          r_push       <= 1'b1;
          r_push_dat   <= '{b: r_shift, st: r_shift, nr: 8'd0, is_st: 1'b1};
          r_cur_status <= r_shift;
          r_nr         <= '0;
        end else begin
          r_push     <= 1'b1;
          r_push_dat <= '{b: r_shift, st: r_cur_status, nr: w_nr_new, is_st: 1'b0};
          r_nr       <= w_nr_new;
        end
      end
    end
  end

  ent_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          r_overrun;
  logic          w_pop, w_full, w_wr;
  ent_t          w_head;

  assign w_pop  = (r_cnt != '0) && out_ready;
  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_wr   = r_push && (!w_full || w_pop);
  assign w_head = r_mem[r_rd];

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_push && !w_wr;
      if (w_wr) begin
        r_mem[r_wr] <= r_push_dat;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_valid     = (r_cnt != '0);
  assign out_byte      = w_head.b;
  assign out_status    = w_head.st;
  assign out_nr        = w_head.nr;
  assign out_is_status = w_head.is_st;
  assign rt_valid      = r_rt_valid;
  assign rt_byte       = r_rt_byte;
  assign frame_err     = r_frame_err;
  assign overrun_err   = r_overrun;
  assign fifo_level    = r_cnt;

endmodule

// File: tb/tb_midi_uart_rx_p.sv
// Directed + randomized bench for midi_uart_rx_p against a byte-level running-status model.
`timescale 1ns/1ps
module tb_midi_uart_rx_p;
  localparam int CLK_HZ = 2500000;
  localparam int BAUD   = 31250;
  localparam int OVS    = 16;
  localparam int DEPTH  = 8;
  localparam int BIT    = (CLK_HZ / (BAUD * OVS)) * OVS;

  logic clk = 1'b0, reset = 1'b1, rxd = 1'b1;
  logic rdy_cmd = 1'b1, rnd_rdy = 1'b0, rand_bit = 1'b0;
  logic out_ready, out_valid, out_is_status, rt_valid, frame_err, overrun_err;
  logic [7:0] out_byte, out_status, out_nr, rt_byte;
  logic [$clog2(DEPTH):0] fifo_level;

  midi_uart_rx_p #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .sys_clk(clk), .reset(reset), .midi_rxd(rxd),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_status(out_status),
    .out_nr(out_nr), .out_is_status(out_is_status), .rt_valid(rt_valid), .rt_byte(rt_byte),
    .frame_err(frame_err), .overrun_err(overrun_err), .fifo_level(fifo_level)
  );

  always #20 clk = ~clk;
  always @(posedge clk) rand_bit <= 1'($urandom_range(0, 1));
  assign out_ready = rnd_rdy ? rand_bit : rdy_cmd;

  int n_tests = 0, n_fail = 0;
  logic [24:0] exp_q[$], got_q[$];
  int exp_rt = 0, exp_fe = 0, exp_ov = 0, rt_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] exp_rt_last = 8'h00, rt_last = 8'h00;
  logic [7:0] m_status = 8'h00;
  int m_nr = 0, m_stored = 0, chk_idx = 0;
  bit m_blocked = 1'b0;

  // Strobe counters count high cycles, so a widened pulse shows up as an extra count.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back({out_byte, out_status, out_nr, out_is_status});
      if (rt_valid) begin rt_cnt++; rt_last = rt_byte; end
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [7:0] b);
    logic [24:0] e;
    if (b >= 8'hF8) begin
      exp_rt++;
      exp_rt_last = b;
      return;
    end
    if (b == 8'hF7) begin
      e = {8'hF7, m_status, 8'h00, 1'b1};
      m_status = 8'h00;
      m_nr = 0;
    end else if (b >= 8'h80) begin
      m_status = b;
      m_nr = 0;
      e = {b, b, 8'h00, 1'b1};
    end else begin
      if (m_nr < 255) m_nr++;
      e = {b, m_status, 8'(m_nr), 1'b0};
    end
    if (m_blocked && m_stored == DEPTH) exp_ov++;
    else begin
      exp_q.push_back(e);
      if (m_blocked) m_stored++;
    end
  endfunction

  task automatic send(input logic [7:0] b, input bit stop_ok, input int skew, input int gap);
    if (stop_ok) model(b); else exp_fe++;
    rxd = 1'b0;
    repeat (BIT + skew) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(posedge clk);
    end
    rxd = stop_ok;
    repeat (BIT) @(posedge clk);
    rxd = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic checkpoint(input string tag);
    repeat (20) @(posedge clk);
    for (int i = 0; i < 1000 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    chk({tag, " entries"}, got_q.size(), exp_q.size());
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s entry%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, " rt_count"}, rt_cnt, exp_rt);
    chk({tag, " frame_err_count"}, fe_cnt, exp_fe);
    chk({tag, " overrun_count"}, ov_cnt, exp_ov);
    chk_idx = exp_q.size();
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset fifo_level", fifo_level, 0);
    chk("reset rt_valid", rt_valid, 0);
    chk("reset rt_byte", rt_byte, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun_err", overrun_err, 0);
    chk("reset out_byte", out_byte, 0);
    reset = 1'b0;
    repeat (BIT) @(posedge clk);

    send(8'h90, 1, 0, 0); send(8'h3C, 1, 0, 0); send(8'h64, 1, 0, BIT);
    checkpoint("note_on");
    send(8'h40, 1, 0, 0); send(8'h00, 1, 0, BIT);
    checkpoint("running_status");

    send(8'h90, 1, 0, 0); send(8'hF8, 1, 0, 0); send(8'h3C, 1, 0, BIT);
    checkpoint("realtime_mid");
    chk("rt_byte captured", rt_last, exp_rt_last);
    chk("rt_byte held", rt_byte, 8'hF8);

    send(8'h55, 0, 0, 2 * BIT);
    checkpoint("frame_err");
    send(8'h80, 1, 0, BIT);
    checkpoint("after_break");

    rxd = 1'b0; repeat (BIT * 3 / 8) @(posedge clk); rxd = 1'b1;
    repeat (BIT * 12) @(posedge clk);
    checkpoint("glitch");

    send(8'h12, 1, -3, BIT); send(8'h7F, 1, 3, BIT);
    checkpoint("skew");

    send(8'hB0, 1, 0, BIT);
    checkpoint("ovr_status");
    rdy_cmd = 1'b0; m_blocked = 1'b1; m_stored = 0;
    for (int i = 1; i <= 9; i++) send(8'(i * 7), 1, 0, 0);
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("full fifo_level", fifo_level, DEPTH);
    chk("full out_valid", out_valid, 1);
    chk("full overrun_count", ov_cnt, exp_ov);
    rdy_cmd = 1'b1; m_blocked = 1'b0;
    checkpoint("drain");
    @(negedge clk);
    chk("drained fifo_level", fifo_level, 0);
    send(8'h11, 1, 0, BIT);
    checkpoint("nr_after_drop");

    rnd_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int k;
      logic [7:0] b;
      k = $urandom_range(0, 9);
      if (k <= 4 || k == 9) b = 8'($urandom_range(0, 8'h7F));
      else if (k <= 6)      b = 8'($urandom_range(8'h80, 8'hF6));
      else if (k == 7)      b = 8'hF7;
      else                  b = 8'($urandom_range(8'hF8, 8'hFF));
      send(b, 1, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 1)) * BIT / 2);
    end
    rnd_rdy = 1'b0; rdy_cmd = 1'b1;
    repeat (BIT) @(posedge clk);
    checkpoint("random");

    rdy_cmd = 1'b0; m_blocked = 1'b1; m_stored = 0;
    send(8'h90, 1, 0, BIT);
    @(negedge clk);
    chk("pre_reset fifo_level", fifo_level, 1);
    rxd = 1'b0;
    repeat (BIT * 4) @(posedge clk);
    reset = 1'b1; rxd = 1'b1;
    @(negedge clk);
    chk("midreset fifo_level", fifo_level, 0);
    chk("midreset out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    reset = 1'b0;
    while (m_stored > 0) begin void'(exp_q.pop_back()); m_stored--; end
    m_blocked = 1'b0; m_status = 8'h00; m_nr = 0; rdy_cmd = 1'b1;
    repeat (BIT * 12) @(posedge clk);
    checkpoint("midreset_quiet");
    send(8'h3C, 1, 0, BIT);
    checkpoint("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
